// File: rtl/fp32_mul_console.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp32_mul_console: switch-entry FP32 multiplier with 8-digit 7-seg console.  |
// | Optional macro ROUND_NEAREST_EN: round-to-nearest-even instead of truncate. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fp32_mul_console #(
  parameter int FILTER_SIZE = 2,
  parameter int SCAN_DIV    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        btn_in,
  input  logic        btn_nxt,
  input  logic        btn_rst,
  output logic [1:0]  err_out,
  output logic [7:0]  AN,
  output logic [6:0]  SEG
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IN_AH, IN_AL, IN_BH, IN_BL, CALC, SHOW} state_t;

  logic [2:0] w_raw;
  logic [2:0] w_pulse;
  logic       w_soft;

  assign w_raw  = {btn_rst, btn_nxt, btn_in};
  assign w_soft = w_pulse[2];

  // Debounce: level follows the input only after 2**FILTER_SIZE equal samples.
  for (genvar gi = 0; gi < 3; gi++) begin : g_filter
    logic                   r_sync;
    logic                   r_smp;
    logic                   r_lvl;
    logic                   r_lvl_d;
    logic [FILTER_SIZE-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync  <= 1'b0;
        r_smp   <= 1'b0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
        r_cnt   <= '0;
      end else if (w_soft) begin
        r_sync  <= 1'b0;
        r_smp   <= 1'b0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync  <= w_raw[gi];
        r_smp   <= r_sync;
        r_lvl_d <= r_lvl;
        if (r_sync != r_smp) begin
          r_cnt <= '0;
        end else if (r_cnt != {FILTER_SIZE{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_lvl <= r_smp;
        end
      end
    end

    assign w_pulse[gi] = r_lvl & ~r_lvl_d;
  end

  state_t              r_state;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [31:0]         r_res;
  logic [1:0]          r_err;
  logic [1:0]          r_page;
  logic [4:0]          r_cyc;
  logic                r_sign;
  logic                r_nan;
  logic                r_zero;
  logic signed [9:0]   r_exp;
  logic [47:0]         r_acc;
  logic [47:0]         r_mcand;
  logic [23:0]         r_mplier;

  logic                w_hi;
  logic signed [9:0]   w_exp;
  logic [22:0]         w_mant;
  logic [31:0]         w_res;
  logic [1:0]          w_err;

`ifdef ROUND_NEAREST_EN
  logic                w_guard;
  logic                w_sticky;
`else
  logic                w_unused_lsbs;
  assign w_unused_lsbs = ^r_acc[22:0];
`endif

  // Normalise and pack the finished 48-bit mantissa product.
  always_comb begin
    w_hi   = r_acc[47];
    w_exp  = r_exp + (w_hi ? 10'sd1 : 10'sd0);
    w_mant = w_hi ? r_acc[46:24] : r_acc[45:23];
`ifdef ROUND_NEAREST_EN
    w_guard  = w_hi ? r_acc[23] : r_acc[22];
    w_sticky = w_hi ? |r_acc[22:0] : |r_acc[21:0];
    if (w_guard && (w_sticky || w_mant[0])) begin
      if (&w_mant) begin
        w_mant = '0;
        w_exp  = w_exp + 10'sd1;
      end else begin
        w_mant = w_mant + 23'd1;
      end
    end
`endif
    if (r_nan) begin
      w_res = 32'h7FC00000;
      w_err = 2'b11;
    end else if (r_zero) begin
      w_res = {r_sign, 31'b0};
      w_err = 2'b00;
    end else if (w_exp > 10'sd254) begin
      w_res = {r_sign, 8'hFF, 23'b0};
      w_err = 2'b01;
    end else if (w_exp < 10'sd1) begin
      w_res = {r_sign, 31'b0};
      w_err = 2'b10;
    end else begin
      w_res = {r_sign, w_exp[7:0], w_mant};
      w_err = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IN_AH;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_err    <= 2'b00;
      r_page   <= 2'd2;
      r_cyc    <= '0;
      r_sign   <= 1'b0;
      r_nan    <= 1'b0;
      r_zero   <= 1'b0;
      r_exp    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_soft) begin
      r_state  <= IN_AH;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_err    <= 2'b00;
      r_page   <= 2'd2;
      r_cyc    <= '0;
      r_sign   <= 1'b0;
      r_nan    <= 1'b0;
      r_zero   <= 1'b0;
      r_exp    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_state)
        IN_AH: if (w_pulse[0]) begin r_a[31:16] <= data_in; r_state <= IN_AL; end
        IN_AL: if (w_pulse[0]) begin r_a[15:0]  <= data_in; r_state <= IN_BH; end
        IN_BH: if (w_pulse[0]) begin r_b[31:16] <= data_in; r_state <= IN_BL; end
        IN_BL: if (w_pulse[0]) begin
          r_b[15:0] <= data_in;
          r_cyc     <= '0;
          r_state   <= CALC;
        end
        CALC: begin
          r_cyc <= r_cyc + 5'd1;
          if (r_cyc == 5'd0) begin
            r_sign   <= r_a[31] ^ r_b[31];
            r_nan    <= (r_a[30:23] == 8'hFF) || (r_b[30:23] == 8'hFF);
            r_zero   <= (r_a[30:23] == 8'h00) || (r_b[30:23] == 8'h00);
            r_exp    <= $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]}) - 10'sd127;
            r_acc    <= '0;
            r_mcand  <= {24'b0, 1'b1, r_a[22:0]};
            r_mplier <= {1'b1, r_b[22:0]};
          end else if (r_cyc <= 5'd24) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else begin
            r_res   <= w_res;
            r_err   <= w_err;
            r_page  <= 2'd2;
            r_state <= SHOW;
          end
        end
        SHOW: if (w_pulse[1]) r_page <= (r_page == 2'd2) ? 2'd0 : r_page + 2'd1;
        default: r_state <= IN_AH;
      endcase
    end
  end

  assign err_out = r_err;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_digit;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic [31:0]      w_word;
  logic [1:0]       w_slot;
  logic [4:0]       w_code;

  // Digit code: bit 4 set means blank, otherwise a hex nibble.
  always_comb begin
    w_word = 32'h0;
    w_slot = 2'd0;
    w_code = 5'h10;
    case (r_state)
      IN_AH, IN_AL, IN_BH, IN_BL: begin
        case (r_state)
          IN_AL:   w_slot = 2'd1;
          IN_BH:   w_slot = 2'd2;
          IN_BL:   w_slot = 2'd3;
          default: w_slot = 2'd0;
        endcase
        w_word = {16'h0, data_in};
        if (r_digit == 3'd7)     w_code = {3'b000, w_slot};
        else if (!r_digit[2])    w_code = {1'b0, w_word[{r_digit, 2'b00} +: 4]};
      end
      SHOW: begin
        case (r_page)
          2'd0:    w_word = r_a;
          2'd1:    w_word = r_b;
          default: w_word = r_res;
        endcase
        w_code = {1'b0, w_word[{r_digit, 2'b00} +: 4]};
      end
      default: w_code = 5'h10;
    endcase
  end

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'h00: glyph = 7'h40;  5'h01: glyph = 7'h79;
      5'h02: glyph = 7'h24;  5'h03: glyph = 7'h30;
      5'h04: glyph = 7'h19;  5'h05: glyph = 7'h12;
      5'h06: glyph = 7'h02;  5'h07: glyph = 7'h78;
      5'h08: glyph = 7'h00;  5'h09: glyph = 7'h10;
      5'h0A: glyph = 7'h08;  5'h0B: glyph = 7'h03;
      5'h0C: glyph = 7'h46;  5'h0D: glyph = 7'h21;
      5'h0E: glyph = 7'h06;  5'h0F: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_digit <= '0;
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
    end else if (w_soft) begin
      r_div   <= '0;
      r_digit <= '0;
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
    end else begin
      r_an  <= ~(8'b1 << r_digit);
      r_seg <= glyph(w_code);
      if (r_div == DIV_W'(SCAN_DIV - 1)) begin
        r_div   <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_console.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp32_mul_console: randomized bench for fp32_mul_console with FP model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fp32_mul_console;

  localparam int FS = 2;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        btn_in = 1'b0;
  logic        btn_nxt = 1'b0;
  logic        btn_rst = 1'b0;
  logic [1:0]  err_out;
  logic [7:0]  AN;
  logic [6:0]  SEG;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  fp32_mul_console #(.FILTER_SIZE(FS), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .btn_in(btn_in), .btn_nxt(btn_nxt),
    .btn_rst(btn_rst), .err_out(err_out), .AN(AN), .SEG(SEG)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 16 = blank, 31 = unrecognised segment pattern
  function automatic logic [4:0] seg2code(input logic [6:0] s);
    if (s == 7'h7F) return 5'd16;
    for (int i = 0; i < 16; i++) if (GLYPH[i] == s) return 5'(i);
    return 5'd31;
  endfunction

  function automatic logic [39:0] word_disp(input logic [31:0] w);
    logic [39:0] d;
    for (int i = 0; i < 8; i++) d[i*5 +: 5] = {1'b0, w[i*4 +: 4]};
    return d;
  endfunction

  function automatic logic [39:0] input_disp(input int slot, input logic [15:0] v);
    logic [39:0] d;
    d = word_disp({16'h0, v});
    d[39:35] = 5'(slot);
    for (int i = 4; i < 7; i++) d[i*5 +: 5] = 5'd16;
    return d;
  endfunction

  // Reference: exact integer mantissa product, then the IEEE rules of the console.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    logic s = a[31] ^ b[31];
    longint unsigned p, m;
    int e, sh;
    if (ea == 255 || eb == 255) return {2'b11, 32'h7FC00000};
    if (ea == 0 || eb == 0) return {2'b00, s, 31'b0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin e++; sh = 24; end else sh = 23;
    m = p >> sh;
`ifdef ROUND_NEAREST_EN
    begin
      longint unsigned rem, half;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m++;
      if (m >= (64'd1 << 24)) begin m = m >> 1; e++; end
    end
`endif
    if (e > 254) return {2'b01, s, 8'hFF, 23'b0};
    if (e < 1) return {2'b10, s, 31'b0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  task automatic read_display(output logic [39:0] disp);
    logic [7:0] seen = 8'h00;
    disp = '1;
    for (int c = 0; c < 40 * SD && seen != 8'hFF; c++) begin
      @(negedge clk);
      for (int d = 0; d < 8; d++) begin
        if (AN == ~(8'b1 << d)) begin
          disp[d*5 +: 5] = seg2code(SEG);
          seen[d] = 1'b1;
        end
      end
    end
    check_val("scan_all_digits", 64'(seen), 64'hFF);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_in = 1'b1;
      1: btn_nxt = 1'b1;
      default: btn_rst = 1'b1;
    endcase
    repeat (12) @(negedge clk);
    btn_in = 1'b0;
    btn_nxt = 1'b0;
    btn_rst = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic enter_ops(input logic [31:0] a, input logic [31:0] b);
    data_in = a[31:16]; press(0);
    data_in = a[15:0];  press(0);
    data_in = b[31:16]; press(0);
    data_in = b[15:0];  press(0);
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] exp;
    logic [39:0] disp;
    exp = ref_mul(a, b);
    enter_ops(a, b);
    repeat (40) @(negedge clk);
    check_val($sformatf("%s_err", tag), 64'(err_out), 64'(exp[33:32]));
    read_display(disp);
    check_val($sformatf("%s_result", tag), 64'(disp), 64'(word_disp(exp[31:0])));
    press(2);
  endtask

  function automatic logic [31:0] rand_op();
    int kind = $urandom_range(0, 9);
    logic [7:0] e;
    case (kind)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(200, 254));
      3:       e = 8'($urandom_range(1, 50));
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    logic [39:0] disp;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check_val("reset_an", 64'(AN), 64'hFF);
    check_val("reset_seg", 64'(SEG), 64'h7F);
    check_val("reset_err", 64'(err_out), 64'h0);
    rst_n = 1'b1;

    data_in = 16'hBEEF;
    read_display(disp);
    check_val("input_slot0", 64'(disp), 64'(input_disp(0, 16'hBEEF)));
    data_in = 16'h4120;
    press(0);
    data_in = 16'h9C3D;
    read_display(disp);
    check_val("input_slot1", 64'(disp), 64'(input_disp(1, 16'h9C3D)));
    press(2);

    run_case("mul_5x7", 32'h40A00000, 32'h40E00000);

    enter_ops(32'h40A00000, 32'h40E00000);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      press(1);
      read_display(disp);
      case (i % 3)
        0: check_val($sformatf("page_%0d_A", i), 64'(disp), 64'(word_disp(32'h40A00000)));
        1: check_val($sformatf("page_%0d_B", i), 64'(disp), 64'(word_disp(32'h40E00000)));
        default: check_val($sformatf("page_%0d_R", i), 64'(disp), 64'(word_disp(32'h420C0000)));
      endcase
    end
    press(2);
    data_in = 16'h1234;
    read_display(disp);
    check_val("soft_reset_display", 64'(disp), 64'(input_disp(0, 16'h1234)));
    check_val("soft_reset_err", 64'(err_out), 64'h0);

    run_case("overflow", 32'h7F000000, 32'h40000000);
    run_case("underflow", 32'h00800000, 32'h00800000);
    run_case("nan_inf", 32'h7F800000, 32'($urandom));

    // Soft reset landing while the multiplier is still busy.
    data_in = 16'h40A0; press(0);
    data_in = 16'h0000; press(0);
    data_in = 16'h40E0; press(0);
    data_in = 16'h0000;
    @(negedge clk);
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    btn_rst = 1'b1;
    repeat (10) @(negedge clk);
    btn_rst = 1'b0;
    repeat (40) @(negedge clk);
    data_in = 16'hA5C3;
    read_display(disp);
    check_val("midcalc_reset_display", 64'(disp), 64'(input_disp(0, 16'hA5C3)));
    check_val("midcalc_reset_err", 64'(err_out), 64'h0);
    run_case("reentry_5x7", 32'h40A00000, 32'h40E00000);

    for (int i = 0; i < 8; i++) begin
      a = rand_op();
      b = rand_op();
      run_case($sformatf("rand%0d_%h_%h", i, a, b), a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
